// File: rtl/planet_emp_game_ctrl.sv
// Round sequencer for the Planet Empire core: arming, hit/miss judgement, score/shot
// tally, empire speed level and sound selection. All durations count EE_i ticks.
module planet_emp_game_ctrl #(
  parameter int C_SHOTS     = 10,
  parameter int C_ARM_N     = 2000,
  parameter int C_HIT_N     = 300,
  parameter int C_MISS_N    = 150,
  parameter int C_LVUP_HITS = 4,
  parameter int C_MAX_LV    = 3
) (
  input  logic       CK_i,
  input  logic       SRST_i,
  input  logic       EE_i,
  input  logic       FIRE_i,
  input  logic       MSL_TOP_i,
  input  logic       EMP_HIT_i,
  input  logic       EMP_FULL_i,
  output logic       FIRE_EN_o,
  output logic       EMP_CLR_o,
  output logic       EMP_KILL_o,
  output logic [1:0] EMP_LV_o,
  output logic [7:0] SCORE_o,
  output logic [7:0] SHOTS_o,
  output logic [1:0] SND_o,
  output logic       OVER_o,
  output logic [2:0] STATE_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_READY = 3'd2, S_FLIGHT = 3'd3,
    S_HIT = 3'd4, S_MISS = 3'd5, S_OVER = 3'd6, S_BAD = 3'd7
  } state_t;

  localparam int TMAX0 = (C_ARM_N > C_HIT_N) ? C_ARM_N : C_HIT_N;
  localparam int TMAX  = (TMAX0 > C_MISS_N) ? TMAX0 : C_MISS_N;
  localparam int TW    = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_ARM  = TW'(C_ARM_N - 1);
  localparam logic [TW-1:0] T_HIT  = TW'(C_HIT_N - 1);
  localparam logic [TW-1:0] T_MISS = TW'(C_MISS_N - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TMAX);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    score_q, score_d, shots_q, shots_d, hctr_q, hctr_d;
  logic [1:0]    lv_q, lv_d;
  logic          fire_q, msl_q, clr_q, clr_d, kill_q, kill_d;
  logic          fire_rise, msl_rise, exit_now;

  assign fire_rise = FIRE_i & ~fire_q;
  assign msl_rise  = MSL_TOP_i & ~msl_q;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    shots_d  = shots_q;
    hctr_d   = hctr_q;
    lv_d     = lv_q;
    clr_d    = 1'b0;
    kill_d   = 1'b0;
    exit_now = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: if (fire_rise) begin
        state_d = S_ARM;
        score_d = '0;
        shots_d = 8'(C_SHOTS);
        hctr_d  = '0;
        lv_d    = '0;
        clr_d   = 1'b1;
      end
      S_ARM: begin
        if (EMP_FULL_i)                 state_d = S_OVER;
        else if (EE_i && tmr_q == T_ARM) state_d = S_READY;
      end
      S_READY: begin
        if (EMP_FULL_i) state_d = S_OVER;
        else if (fire_rise) begin
          state_d = S_FLIGHT;
          shots_d = shots_q - 8'd1;
        end
      end
      // The shot is judged before any invasion; HIT/MISS then react to EMP_FULL_i.
      S_FLIGHT: if (msl_rise) begin
        if (EMP_HIT_i) begin
          state_d = S_HIT;
          kill_d  = 1'b1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          if (hctr_q + 8'd1 == 8'(C_LVUP_HITS)) begin
            hctr_d = '0;
            if (lv_q != 2'(C_MAX_LV)) lv_d = lv_q + 2'd1;
          end else begin
            hctr_d = hctr_q + 8'd1;
          end
        end else begin
          state_d = S_MISS;
        end
      end
      S_HIT, S_MISS: begin
        exit_now = EE_i && (tmr_q == ((state_q == S_HIT) ? T_HIT : T_MISS));
        if (EMP_FULL_i)    state_d = S_OVER;
        else if (exit_now) state_d = (shots_q == 8'd0) ? S_OVER : S_READY;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q)           tmr_d = '0;
    else if (EE_i && tmr_q != T_SAT)  tmr_d = tmr_q + 1'b1;
    else                              tmr_d = tmr_q;
  end

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      score_q <= '0;
      shots_q <= 8'(C_SHOTS);
      hctr_q  <= '0;
      lv_q    <= '0;
      fire_q  <= 1'b1;
      msl_q   <= 1'b0;
      clr_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      score_q <= score_d;
      shots_q <= shots_d;
      hctr_q  <= hctr_d;
      lv_q    <= lv_d;
      fire_q  <= FIRE_i;
      msl_q   <= MSL_TOP_i;
      clr_q   <= clr_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    SND_o = 2'b00;
    case (state_q)
      S_HIT:  SND_o = 2'b10;
      S_MISS: SND_o = 2'b01;
      S_OVER: if (tmr_q < TW'(C_HIT_N)) SND_o = 2'b11;
      default: SND_o = 2'b00;
    endcase
  end

  assign FIRE_EN_o  = (state_q == S_FLIGHT);
  assign OVER_o     = (state_q == S_OVER);
  assign EMP_CLR_o  = clr_q;
  assign EMP_KILL_o = kill_q;
  assign EMP_LV_o   = lv_q;
  assign SCORE_o    = score_q;
  assign SHOTS_o    = shots_q;
  assign STATE_o    = state_q;
endmodule

// File: tb/tb_planet_emp_game_ctrl.sv
// Bench for planet_emp_game_ctrl: reset/arming sequences, a table of shots checked via a
// scoreboard queue, and hand-written invasion / reset corner cases.
module tb_planet_emp_game_ctrl;
  localparam int NSH = 20;

  logic clk = 1'b0, srst, ee, fire, msl, ehit, efull;
  logic fire_en, eclr, ekill, over;
  logic [1:0] lv, snd;
  logic [7:0] score, shots;
  logic [2:0] st;

  planet_emp_game_ctrl #(
    .C_SHOTS(NSH), .C_ARM_N(4), .C_HIT_N(3), .C_MISS_N(2), .C_LVUP_HITS(4), .C_MAX_LV(3)
  ) dut (
    .CK_i(clk), .SRST_i(srst), .EE_i(ee), .FIRE_i(fire), .MSL_TOP_i(msl),
    .EMP_HIT_i(ehit), .EMP_FULL_i(efull), .FIRE_EN_o(fire_en), .EMP_CLR_o(eclr),
    .EMP_KILL_o(ekill), .EMP_LV_o(lv), .SCORE_o(score), .SHOTS_o(shots),
    .SND_o(snd), .OVER_o(over), .STATE_o(st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    int   st, score, shots, lv, kill, snd, nxt;
  } vec_t;

  vec_t tbl[NSH];
  vec_t sb[$];
  int   total = 0, passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      ee = 1'b1; cyc(); ee = 1'b0; cyc();
    end
  endtask

  task automatic press();
    fire = 1'b0; cyc(); fire = 1'b1; cyc(); fire = 1'b0;
  endtask

  task automatic wait_leave(input int want);
    int k;
    k = 0;
    while (st != 3'd2 && st != 3'd6 && k < 20) begin tick(1); k++; end
    chk("exit_state", int'(st), want);
  endtask

  initial begin
    int sc, l, hc, sh;
    vec_t e;
    sc = 0; l = 0; hc = 0; sh = NSH;
    for (int i = 0; i < NSH; i++) begin
      tbl[i].hit = (i < NSH - 1);
      sh--;
      if (tbl[i].hit) begin
        sc++; hc++;
        if (hc == 4) begin hc = 0; if (l < 3) l++; end
      end
      tbl[i].st = tbl[i].hit ? 4 : 5;
      tbl[i].score = sc; tbl[i].shots = sh; tbl[i].lv = l;
      tbl[i].kill = tbl[i].hit ? 1 : 0;
      tbl[i].snd = tbl[i].hit ? 2 : 1;
      tbl[i].nxt = (sh == 0) ? 6 : 2;
    end

    // Reset with the button already held.
    srst = 1'b1; ee = 1'b0; fire = 1'b1; msl = 1'b0; ehit = 1'b0; efull = 1'b0;
    cyc(); cyc(); srst = 1'b0;
    chk("rst_state", int'(st), 0);
    chk("rst_shots", int'(shots), NSH);
    chk("rst_score", int'(score), 0);
    chk("rst_snd", int'(snd), 0);
    chk("rst_outs", int'({fire_en, eclr, ekill, over, lv}), 0);
    cyc(); cyc();
    chk("held_fire_idle", int'(st), 0);
    press();
    chk("arm_state", int'(st), 1);
    chk("emp_clr_pulse", int'(eclr), 1);
    cyc();
    chk("emp_clr_end", int'(eclr), 0);
    press();
    chk("fire_ignored_arm", int'(st), 1);

    tick(3);
    chk("arm_not_done", int'(st), 1);
    tick(1);
    chk("ready_state", int'(st), 2);

    // Table of shots: expected record pushed at the missile edge, popped at judgement.
    for (int i = 0; i < NSH; i++) begin
      int k;
      press();
      chk("flight_state", int'(st), 3);
      chk("flight_fire_en", int'(fire_en), 1);
      msl = 1'b1; ehit = tbl[i].hit;
      sb.push_back(tbl[i]);
      k = 0;
      do begin cyc(); k++; end while (st != 3'd4 && st != 3'd5 && k < 5);
      if (sb.size() == 0) chk("sb_empty", 0, 1);
      else begin
        e = sb.pop_front();
        chk("judge_state", int'(st), e.st);
        chk("score", int'(score), e.score);
        chk("shots", int'(shots), e.shots);
        chk("level", int'(lv), e.lv);
        chk("kill", int'(ekill), e.kill);
        chk("snd", int'(snd), e.snd);
        chk("fire_en_off", int'(fire_en), 0);
        msl = 1'b0; ehit = 1'b0;
        cyc();
        chk("kill_end", int'(ekill), 0);
        wait_leave(e.nxt);
      end
    end

    chk("over_flag", int'(over), 1);
    chk("over_snd", int'(snd), 3);
    tick(2);
    chk("over_snd_hold", int'(snd), 3);
    tick(1);
    chk("over_snd_quiet", int'(snd), 0);
    press();
    chk("restart_state", int'(st), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_shots", int'(shots), NSH);
    chk("restart_lv", int'(lv), 0);
    chk("restart_clr", int'(eclr), 1);

    // Invasion in READY.
    tick(4);
    chk("ready2", int'(st), 2);
    efull = 1'b1; cyc(); efull = 1'b0;
    chk("full_ready_over", int'(st), 6);

    // Missile edge and invasion in the same FLIGHT cycle: hit first, then OVER.
    press(); tick(4); press();
    chk("flight2", int'(st), 3);
    msl = 1'b1; ehit = 1'b1; efull = 1'b1; cyc();
    chk("full_flight_hit", int'(st), 4);
    chk("full_flight_score", int'(score), 1);
    cyc();
    chk("full_hit_over", int'(st), 6);
    msl = 1'b0; ehit = 1'b0; efull = 1'b0;

    // Reset in the middle of the hit jingle.
    press(); tick(4); press();
    msl = 1'b1; ehit = 1'b1; cyc();
    chk("hit3", int'(st), 4);
    tick(1);
    chk("mid_jingle_snd", int'(snd), 2);
    msl = 1'b0; ehit = 1'b0;
    srst = 1'b1; cyc(); srst = 1'b0;
    chk("srst_hit_state", int'(st), 0);
    chk("srst_hit_snd", int'(snd), 0);
    chk("srst_hit_score", int'(score), 0);
    chk("srst_hit_shots", int'(shots), NSH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
